// File: rtl/iic_arb_pkg.sv
// iic_arb_pkg: shared definitions for the camera SCCB/I2C bus arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE=0, ISSUE=1, BUSY=2, RELEASE=3)
//   - IIC_ADDR_W / IIC_NUM_W / IIC_DATA_W : per-requester field widths
package iic_arb_pkg;

  localparam int IIC_ADDR_W = 16;
  localparam int IIC_NUM_W  = 6;
  localparam int IIC_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/iic_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   pend [NUM_REQ-1:0] : pending requesters
//   ptr  [IDX_W-1:0]   : index with highest priority this round
//   win  [IDX_W-1:0]   : first pending index at or after ptr (wrapping)
//   vld                : at least one requester pending
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               vld
);

  // Rotate so that bit 0 is the requester at ptr; the first set bit of
  // rot then gives the winner's offset from ptr.
  logic [NUM_REQ-1:0] rot;
  int                 sum;

  assign rot = (pend >> ptr) | (pend << (NUM_REQ - int'(ptr)));

  always_comb begin
    win = '0;
    vld = 1'b0;
    sum = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!vld && rot[i]) begin
        vld = 1'b1;
        sum = int'(ptr) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/iic_bus_arbiter.sv
// iic_bus_arbiter: shares one SCCB/I2C driver between NUM_REQ requesters.
// Round-robin arbitration, one transaction at a time, driver handshakes
// routed back to the owning requester only.
//
// Handshake: i_req_wr/i_req_rd are levels held by a requester until its
// o_done pulse. o_drv_wr_req/o_drv_rd_req are single-cycle pulses. Driver
// pulses (new_byte, rd_vld, done, error) are forwarded to bit [owner] only
// while the FSM is in ISSUE or BUSY; at any other time they are dropped.
//
// Ports: clk, rst_n (async, active low); per-requester packed request
// fields i_req_*; per-requester routed returns o_gnt, o_req_new_byte,
// o_rd_vld, o_done, o_error; broadcast o_rd_data; driver side o_drv_* /
// i_drv_*; o_dbg_state exposes the FSM state.
//
// Optional build macro IIC_ARB_TIMEOUT_EN: a BUSY watchdog of TIMEOUT_CYC
// cycles that ends a stuck transaction with o_done and o_error.
module iic_bus_arbiter
  import iic_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req_wr,
  input  logic [NUM_REQ-1:0]      i_req_rd,
  input  logic [16*NUM_REQ-1:0]   i_req_addr,
  input  logic [6*NUM_REQ-1:0]    i_req_wr_num,
  input  logic [6*NUM_REQ-1:0]    i_req_rd_num,
  input  logic [8*NUM_REQ-1:0]    i_req_wr_data,
  output logic [NUM_REQ-1:0]      o_gnt,
  output logic [NUM_REQ-1:0]      o_req_new_byte,
  output logic [7:0]              o_rd_data,
  output logic [NUM_REQ-1:0]      o_rd_vld,
  output logic [NUM_REQ-1:0]      o_done,
  output logic [NUM_REQ-1:0]      o_error,
  output logic [15:0]             o_drv_addr,
  output logic                    o_drv_wr_req,
  output logic                    o_drv_rd_req,
  output logic [5:0]              o_drv_wr_num,
  output logic [5:0]              o_drv_rd_num,
  output logic [7:0]              o_drv_wr_data,
  input  logic                    i_drv_new_byte,
  input  logic [7:0]              i_drv_rd_byte,
  input  logic                    i_drv_rd_vld,
  input  logic                    i_drv_done,
  input  logic                    i_drv_error,
  output logic [1:0]              o_dbg_state
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     win;
  logic                 win_vld;
  logic                 win_wr;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 active;
  logic                 tmo_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .pend (i_req_wr | i_req_rd),
    .ptr  (ptr),
    .win  (win),
    .vld  (win_vld)
  );

  assign win_oh   = NUM_REQ'(1) << win;
  assign owner_oh = NUM_REQ'(1) << owner;
  // Write wins when a requester raises both wr and rd.
  assign win_wr   = |(i_req_wr & win_oh);
  assign active   = (state == ISSUE) || (state == BUSY);

`ifdef IIC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] tmo_cnt;

  // Held at zero outside BUSY, so it restarts for every transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state != BUSY)  tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == BUSY) && (tmo_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      o_gnt        <= '0;
      o_drv_wr_req <= 1'b0;
      o_drv_rd_req <= 1'b0;
      o_drv_addr   <= '0;
      o_drv_wr_num <= '0;
      o_drv_rd_num <= '0;
    end else begin
      o_drv_wr_req <= 1'b0;
      o_drv_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner        <= win;
            o_drv_addr   <= IIC_ADDR_W'(i_req_addr   >> (IIC_ADDR_W * int'(win)));
            o_drv_wr_num <= IIC_NUM_W'(i_req_wr_num  >> (IIC_NUM_W  * int'(win)));
            o_drv_rd_num <= IIC_NUM_W'(i_req_rd_num  >> (IIC_NUM_W  * int'(win)));
            o_gnt        <= win_oh;
            o_drv_wr_req <= win_wr;
            o_drv_rd_req <= !win_wr;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          if (i_drv_done || tmo_hit) begin
            o_gnt <= '0;
            ptr   <= (int'(owner) + 1 >= NUM_REQ) ? '0 : owner + 1'b1;
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: only the owner sees driver activity, and only while its
  // transaction is live.
  always_comb begin
    o_req_new_byte = '0;
    o_rd_vld       = '0;
    o_done         = '0;
    o_error        = '0;
    if (active) begin
      if (i_drv_new_byte)          o_req_new_byte = owner_oh;
      if (i_drv_rd_vld)            o_rd_vld       = owner_oh;
      if (i_drv_done || tmo_hit)   o_done         = owner_oh;
      if (i_drv_error || tmo_hit)  o_error        = owner_oh;
    end
  end

  // Owner may update its data after each o_req_new_byte; no register here.
  assign o_drv_wr_data = IIC_DATA_W'(i_req_wr_data >> (IIC_DATA_W * int'(owner)));
  assign o_rd_data     = i_drv_rd_byte;
  assign o_dbg_state   = state;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
module tb_iic_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TO_CYC  = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic [NUM_REQ-1:0]    req_wr, req_rd;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [6*NUM_REQ-1:0]  req_wr_num, req_rd_num;
  logic [8*NUM_REQ-1:0]  req_wr_data;
  logic [NUM_REQ-1:0]    gnt, req_new_byte, rd_vld, done, error;
  logic [7:0]            rd_data, drv_wr_data, drv_rd_byte;
  logic [15:0]           drv_addr;
  logic                  drv_wr_req, drv_rd_req;
  logic [5:0]            drv_wr_num, drv_rd_num;
  logic                  drv_new_byte, drv_rd_vld, drv_done, drv_error;
  logic [1:0]            dbg_state;

  iic_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_wr       (req_wr),
    .i_req_rd       (req_rd),
    .i_req_addr     (req_addr),
    .i_req_wr_num   (req_wr_num),
    .i_req_rd_num   (req_rd_num),
    .i_req_wr_data  (req_wr_data),
    .o_gnt          (gnt),
    .o_req_new_byte (req_new_byte),
    .o_rd_data      (rd_data),
    .o_rd_vld       (rd_vld),
    .o_done         (done),
    .o_error        (error),
    .o_drv_addr     (drv_addr),
    .o_drv_wr_req   (drv_wr_req),
    .o_drv_rd_req   (drv_rd_req),
    .o_drv_wr_num   (drv_wr_num),
    .o_drv_rd_num   (drv_rd_num),
    .o_drv_wr_data  (drv_wr_data),
    .i_drv_new_byte (drv_new_byte),
    .i_drv_rd_byte  (drv_rd_byte),
    .i_drv_rd_vld   (drv_rd_vld),
    .i_drv_done     (drv_done),
    .i_drv_error    (drv_error),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_gnt"},      32'(gnt), 0);
    check({pfx, "_wr_req"},   32'(drv_wr_req), 0);
    check({pfx, "_rd_req"},   32'(drv_rd_req), 0);
    check({pfx, "_addr"},     32'(drv_addr), 0);
    check({pfx, "_wr_num"},   32'(drv_wr_num), 0);
    check({pfx, "_rd_num"},   32'(drv_rd_num), 0);
    check({pfx, "_new_byte"}, 32'(req_new_byte), 0);
    check({pfx, "_rd_vld"},   32'(rd_vld), 0);
    check({pfx, "_done"},     32'(done), 0);
    check({pfx, "_error"},    32'(error), 0);
    check({pfx, "_state"},    32'(dbg_state), 0);
  endtask

  // Waits (bounded) for a driver request pulse; n = negedges waited.
  task automatic wait_issue(input string name, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (drv_wr_req || drv_rd_req) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_issue: no driver request within 20 cycles", name);
    end
  endtask

  // Driver completes, then the bus must release.
  task automatic finish_txn(input string name, input logic [1:0] exp_gnt, input logic err);
    @(posedge clk); #1;
    drv_done  = 1'b1;
    drv_error = err;
    @(negedge clk);
    check({name, "_done"},  32'(done), 32'(exp_gnt));
    check({name, "_error"}, 32'(error), err ? 32'(exp_gnt) : 0);
    check({name, "_pulse_clr"}, 32'(drv_wr_req | drv_rd_req), 0);
    @(posedge clk); #1;
    drv_done  = 1'b0;
    drv_error = 1'b0;
    req_wr    = '0;
    req_rd    = '0;
    @(negedge clk);
    check({name, "_rel_gnt"},   32'(gnt), 0);
    check({name, "_rel_state"}, 32'(dbg_state), 3);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic        err;
    logic [1:0]  exp_gnt;
    logic        exp_wr;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    int    n;
    nm = $sformatf("vec%0d", idx);
    req_wr   = v.wr;
    req_rd   = v.rd;
    req_addr = {v.addr1, v.addr0};
    wait_issue(nm, n);
    check({nm, "_latency"}, 32'(n), 2);
    check({nm, "_gnt"},     32'(gnt), 32'(v.exp_gnt));
    check({nm, "_wr_req"},  32'(drv_wr_req), 32'(v.exp_wr));
    check({nm, "_rd_req"},  32'(drv_rd_req), 32'(!v.exp_wr));
    check({nm, "_addr"},    32'(drv_addr), 32'(v.exp_addr));
    check({nm, "_wr_num"},  32'(drv_wr_num), v.exp_gnt[0] ? 32'd1 : 32'd3);
    check({nm, "_rd_num"},  32'(drv_rd_num), v.exp_gnt[0] ? 32'd4 : 32'd2);
    finish_txn(nm, v.exp_gnt, v.err);
  endtask

  // Safety net against a hung DUT handshake.
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] rd_bytes[2] = '{8'hA5, 8'h3C};
  logic [7:0] wr_bytes[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int n;
    int c;

    // Round-robin pointer starts at 0; expectations follow the pointer.
    vecs[0] = '{2'b01, 2'b00, 16'h0012, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h0012};
    vecs[1] = '{2'b10, 2'b00, 16'h1111, 16'h0222, 1'b0, 2'b10, 1'b1, 16'h0222};
    vecs[2] = '{2'b11, 2'b00, 16'h0300, 16'h0301, 1'b0, 2'b01, 1'b1, 16'h0300};
    vecs[3] = '{2'b11, 2'b00, 16'h0400, 16'h0401, 1'b0, 2'b10, 1'b1, 16'h0401};
    vecs[4] = '{2'b11, 2'b00, 16'h0500, 16'h0501, 1'b0, 2'b01, 1'b1, 16'h0500};
    vecs[5] = '{2'b01, 2'b10, 16'h0600, 16'h0601, 1'b0, 2'b10, 1'b0, 16'h0601};
    vecs[6] = '{2'b10, 2'b10, 16'h0700, 16'h0701, 1'b0, 2'b10, 1'b1, 16'h0701};
    vecs[7] = '{2'b00, 2'b01, 16'h0800, 16'h0801, 1'b1, 2'b01, 1'b0, 16'h0800};
    vecs[8] = '{2'b01, 2'b11, 16'h0900, 16'h0901, 1'b0, 2'b10, 1'b0, 16'h0901};
    vecs[9] = '{2'b01, 2'b01, 16'h0A00, 16'h0A01, 1'b0, 2'b01, 1'b1, 16'h0A00};

    rst_n        = 1'b0;
    req_wr       = '0;
    req_rd       = '0;
    req_addr     = '0;
    req_wr_num   = {6'd3, 6'd1};
    req_rd_num   = {6'd2, 6'd4};
    req_wr_data  = '0;
    drv_new_byte = 1'b0;
    drv_rd_byte  = '0;
    drv_rd_vld   = 1'b0;
    drv_done     = 1'b0;
    drv_error    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // Driver pulses with nobody owning the bus are discarded.
    @(posedge clk); #1;
    drv_done = 1'b1; drv_error = 1'b1; drv_rd_vld = 1'b1; drv_new_byte = 1'b1;
    @(negedge clk);
    check_zero("idle_pulse");
    @(posedge clk); #1;
    drv_done = 1'b0; drv_error = 1'b0; drv_rd_vld = 1'b0; drv_new_byte = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Read routing: requester 1 reads two bytes (pointer now 1).
    req_rd   = 2'b10;
    req_addr = {16'h0B01, 16'h0B00};
    wait_issue("rd_route", n);
    check("rd_route_gnt", 32'(gnt), 32'h2);
    check("rd_route_rd_req", 32'(drv_rd_req), 1);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      drv_rd_vld  = 1'b1;
      drv_rd_byte = rd_bytes[b];
      @(negedge clk);
      check($sformatf("rd_route_vld%0d", b),  32'(rd_vld), 32'h2);
      check($sformatf("rd_route_data%0d", b), 32'(rd_data), 32'(rd_bytes[b]));
      @(posedge clk); #1;
      drv_rd_vld = 1'b0;
      @(negedge clk);
      check($sformatf("rd_route_vld_clr%0d", b), 32'(rd_vld), 0);
    end
    finish_txn("rd_route", 2'b10, 1'b0);

    // Multibyte write: requester 0 sends three bytes; requester 1's data
    // differs so a wrong mux select shows up.
    req_wr      = 2'b01;
    req_wr_data = {8'hEE, wr_bytes[0]};
    wait_issue("mb_wr", n);
    check("mb_wr_gnt",   32'(gnt), 32'h1);
    check("mb_wr_data0", 32'(drv_wr_data), 32'(wr_bytes[0]));
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      drv_new_byte = 1'b1;
      @(negedge clk);
      check($sformatf("mb_wr_new_byte%0d", b), 32'(req_new_byte), 32'h1);
      @(posedge clk); #1;
      drv_new_byte = 1'b0;
      if (b < 2) req_wr_data[7:0] = wr_bytes[b+1];
      #1;
      check($sformatf("mb_wr_track%0d", b), 32'(drv_wr_data), 32'(wr_bytes[(b < 2) ? b + 1 : 2]));
      check($sformatf("mb_wr_nb_clr%0d", b), 32'(req_new_byte), 0);
    end
    finish_txn("mb_wr", 2'b01, 1'b0);

    // Requester drops its request mid-transaction; done still delivered.
    req_wr = 2'b01;
    wait_issue("drop", n);
    @(posedge clk); #1;
    req_wr = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drop_gnt_held", 32'(gnt), 32'h1);
    check("drop_state",    32'(dbg_state), 2);
    finish_txn("drop", 2'b01, 1'b0);

    // Reset in the middle of BUSY (pointer now 1 -> requester 1 owns).
    req_wr = 2'b10;
    wait_issue("mid_rst", n);
    @(posedge clk); #1;
    drv_new_byte = 1'b1;
    @(negedge clk);
    check("mid_rst_nb", 32'(req_new_byte), 32'h2);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    drv_new_byte = 1'b0;
    req_wr       = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef IIC_ARB_TIMEOUT_EN
    // Driver never completes: watchdog ends it, then requester 1 gets in.
    @(posedge clk); #1;
    req_wr = 2'b11;
    wait_issue("tmo", n);
    check("tmo_gnt", 32'(gnt), 32'h1);
    c = 0;
    for (int k = 1; k <= 150 && c == 0; k++) begin
      @(negedge clk);
      if (done != '0) c = k;
    end
    check("tmo_cycles", 32'(c), TO_CYC);
    check("tmo_done",   32'(done), 32'h1);
    check("tmo_error",  32'(error), 32'h1);
    @(posedge clk); #1;
    req_wr = 2'b10;
    @(negedge clk);
    check("tmo_done_clr", 32'(done), 0);
    wait_issue("tmo_next", n);
    check("tmo_next_gnt", 32'(gnt), 32'h2);
    finish_txn("tmo_next", 2'b10, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
